// File: rtl/wave_pkg.sv
// Shared definitions for the wavetable address generators.
// Keeps address-bus sizing identical across counter and wave blocks.
package wave_pkg;

    typedef enum logic [1:0] {
        WAVE_HOLD = 2'd0,
        WAVE_UP   = 2'd1,
        WAVE_DOWN = 2'd2
    } wave_op_e;

    function automatic int wave_count_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Opposing requests cancel, so both-high decodes to hold.
    function automatic wave_op_e wave_op(input logic up, input logic dn);
        wave_op_e op;
        op = WAVE_HOLD;
        unique case (1'b1)
            (up && !dn): op = WAVE_UP;
            (!up && dn): op = WAVE_DOWN;
            default:     op = WAVE_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/wave_counter.sv
// Modulo up/down counter producing a wrapping wavetable address.
// Counts 0..max_val_p inclusive; output comes straight from the register.
module wave_counter
    import wave_pkg::*;
#(
    parameter int max_val_p = 99,
    localparam int width_lp = wave_count_width(max_val_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o
);

    if (max_val_p < 1) begin : g_bad_max
        $error("wave_counter: max_val_p must be >= 1");
    end

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);
    localparam logic [width_lp-1:0] one_lp = width_lp'(1);

    logic [width_lp-1:0] cnt_q;
    logic [width_lp-1:0] cnt_d;
    wave_op_e            op;
    logic                at_max;
    logic                at_zero;

    assign op      = wave_op(up_i, down_i);
    assign at_max  = (cnt_q == max_lp);
    assign at_zero = (cnt_q == '0);

    // Wrap targets are picked before the add, so no carry ever leaks out.
    always_comb begin
        cnt_d = cnt_q;
        unique case (op)
            WAVE_UP:   cnt_d = at_max ? '0 : cnt_q + one_lp;
            WAVE_DOWN: cnt_d = at_zero ? max_lp : cnt_q - one_lp;
            default:   cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: tb/tb_wave_counter.sv
// Scoreboard bench for wave_counter at max 99 and max 4.
// Drivers push expected counts; monitors pop and compare after each edge.
module tb_wave_counter;

    typedef struct {
        logic [6:0] exp;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, up_a = 1'b0, dn_a = 1'b0;
    logic       rst_b = 1'b0, up_b = 1'b0, dn_b = 1'b0;
    logic [6:0] cnt_a;
    logic [2:0] cnt_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wave_counter #(.max_val_p(99)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .up_i(up_a),
        .down_i(dn_a), .count_o(cnt_a)
    );

    wave_counter #(.max_val_p(4)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .up_i(up_b),
        .down_i(dn_b), .count_o(cnt_b)
    );

    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            exp_t e;
            e = q_a.pop_front();
            checks++;
            if (cnt_a !== e.exp) begin
                failures++;
                $display("FAIL %s: max99 count=%0d expected=%0d",
                         e.nm, cnt_a, e.exp);
            end
        end
        if (q_b.size() > 0) begin
            exp_t e;
            e = q_b.pop_front();
            checks++;
            if ({4'd0, cnt_b} !== e.exp) begin
                failures++;
                $display("FAIL %s: max4 count=%0d expected=%0d",
                         e.nm, cnt_b, e.exp);
            end
        end
    end

    task automatic step_a(input logic r, input logic u, input logic d,
                          input int exp, input string nm);
        exp_t e;
        @(negedge clk);
        rst_a = r; up_a = u; dn_a = d;
        e.exp = 7'(exp);
        e.nm  = nm;
        q_a.push_back(e);
    endtask

    task automatic step_b(input logic r, input logic u, input logic d,
                          input int exp, input string nm);
        exp_t e;
        @(negedge clk);
        rst_b = r; up_b = u; dn_b = d;
        e.exp = 7'(exp);
        e.nm  = nm;
        q_b.push_back(e);
    endtask

    int burst1 [7] = '{1, 2, 3, 4, 0, 1, 2};
    int burst2 [7] = '{3, 4, 0, 1, 2, 3, 4};
    int burst3 [7] = '{3, 2, 1, 0, 4, 3, 2};

    initial begin
        int m4;
        // reset held with up high
        step_a(1'b0, 1'b1, 1'b0, 0, "reset_hold0");
        step_a(1'b0, 1'b1, 1'b0, 0, "reset_hold1");
        step_a(1'b1, 1'b1, 1'b0, 1, "first_up");
        step_a(1'b0, 1'b0, 1'b0, 0, "reset_again");
        for (int i = 1; i <= 99; i++) step_a(1'b1, 1'b1, 1'b0, i, "up_seq");
        step_a(1'b1, 1'b1, 1'b0, 0, "up_wrap");
        step_a(1'b1, 1'b0, 1'b1, 99, "down_wrap");
        step_a(1'b1, 1'b0, 1'b1, 98, "down_98");
        step_a(1'b1, 1'b0, 1'b1, 97, "down_97");
        step_a(1'b1, 1'b0, 1'b1, 96, "down_96");
        step_a(1'b0, 1'b0, 1'b1, 0, "reset_down");
        for (int i = 1; i <= 42; i++) step_a(1'b1, 1'b1, 1'b0, i, "to_42");
        for (int i = 0; i < 5; i++) step_a(1'b1, 1'b1, 1'b1, 42, "both_hold");
        for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0, 1'b0, 42, "idle_hold");
        for (int i = 43; i <= 57; i++) step_a(1'b1, 1'b1, 1'b0, i, "to_57");
        step_a(1'b0, 1'b1, 1'b0, 0, "reset_mid");
        step_a(1'b1, 1'b1, 1'b0, 1, "resume_up");
        step_a(1'b0, 1'b1, 1'b1, 0, "reset_both");

        step_b(1'b0, 1'b1, 1'b1, 0, "b_reset");
        foreach (burst1[i]) step_b(1'b1, 1'b1, 1'b0, burst1[i], "b_burst1");
        step_b(1'b1, 1'b0, 1'b0, 2, "b_idle");
        step_b(1'b1, 1'b1, 1'b1, 2, "b_both");
        foreach (burst2[i]) step_b(1'b1, 1'b1, 1'b0, burst2[i], "b_burst2");
        foreach (burst3[i]) step_b(1'b1, 1'b0, 1'b1, burst3[i], "b_down");
        m4 = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(0, 3));
            if (r[0] && !r[1]) m4 = (m4 + 1) % 5;
            else if (!r[0] && r[1]) m4 = (m4 + 4) % 5;
            step_b(1'b1, r[0], r[1], m4, "b_rand");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0",
                     q_a.size() + q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
